alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_issue_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Purpose:
//   Issues one instruction at a time to an external combinational ALU from a
//   four-entry register file. It runs a three-state sequence:
//     IDLE - accept an instruction and capture its source operands.
//     EXEC - present the operands to the ALU and capture its result.
//     WB   - write the result back, update zero_flag, and pulse done.
//   The register file can also be loaded directly at any time and read
//   combinationally for debug.
//
// Ports:
//   clk          in   1       rising-edge clock
//   rst          in   1       asynchronous active-high reset
//   instr_valid  in   1       instruction offered
//   instr        in   8       [7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2
//   instr_ready  out  1       high only in IDLE
//   ld_en        in   1       direct register load strobe
//   ld_addr      in   2       load target register
//   ld_data      in   DATA_W  load value
//   rd_addr      in   2       debug read select
//   rd_data      out  DATA_W  combinational reg[rd_addr]
//   alu_a        out  DATA_W  ALU source 1 (zero outside EXEC)
//   alu_b        out  DATA_W  ALU source 2 (zero outside EXEC)
//   alu_ctrl     out  3       ALU function select (000 outside EXEC)
//   alu_result   in   DATA_W  ALU result
//   alu_zero     in   1       ALU zero flag
//   done         out  1       one-cycle retire pulse
//   zero_flag    out  1       zero flag of the last retired instruction
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [7:0]        instr,
  output logic              instr_ready,
  input  logic              ld_en,
  input  logic [1:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [1:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              done,
  output logic              zero_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_regs [4];
  logic [1:0]        r_rd;
  logic [DATA_W-1:0] r_a_q;
  logic [DATA_W-1:0] r_b_q;
  logic [2:0]        r_ctrl;
  logic [DATA_W-1:0] r_res_q;
  logic              r_z_q;
  logic              r_zero_flag;
  logic              r_done;
  logic              r_ready;

  logic [1:0]        w_op;
  logic [1:0]        w_rd;
  logic [1:0]        w_rs1;
  logic [1:0]        w_rs2;
  logic              w_accept;

  // Opcode to ALU function select.
  function automatic logic [2:0] map_op(input logic [1:0] op);
    case (op)
      2'b00:   map_op = 3'b000;  // add
      2'b01:   map_op = 3'b010;  // sub
      2'b10:   map_op = 3'b100;  // and
      default: map_op = 3'b101;  // or
    endcase
  endfunction

  assign w_op     = instr[7:6];
  assign w_rd     = instr[5:4];
  assign w_rs1    = instr[3:2];
  assign w_rs2    = instr[1:0];
  assign w_accept = instr_valid && r_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
      r_rd        <= '0;
      r_a_q       <= '0;
      r_b_q       <= '0;
      r_ctrl      <= '0;
      r_res_q     <= '0;
      r_z_q       <= 1'b0;
      r_zero_flag <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
    end else begin
      r_done <= 1'b0;

      // Direct load first, so a write-back to the same register later in this
      // block overrides it.
      if (ld_en) r_regs[ld_addr] <= ld_data;

      case (r_state)
        // Stage boundary: accept and capture operands from pre-edge registers.
        IDLE: begin
          if (w_accept) begin
            r_rd    <= w_rd;
            r_a_q   <= r_regs[w_rs1];
            r_b_q   <= r_regs[w_rs2];
            r_ctrl  <= map_op(w_op);
            r_ready <= 1'b0;
            r_state <= EXEC;
          end
        end

        // Stage boundary: capture the ALU result; the operand latches double
        // as the registered ALU drive, so they are cleared on leaving EXEC.
        EXEC: begin
          r_res_q <= alu_result;
          r_z_q   <= alu_zero;
          r_a_q   <= '0;
          r_b_q   <= '0;
          r_ctrl  <= '0;
          r_state <= WB;
        end

        // Stage boundary: retire.
        WB: begin
          r_regs[r_rd] <= r_res_q;
          r_zero_flag  <= r_z_q;
          r_done       <= 1'b1;
          r_ready      <= 1'b1;
          r_state      <= IDLE;
        end

        default: begin
          r_ready <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign instr_ready = r_ready;
  assign rd_data     = r_regs[rd_addr];
  assign alu_a       = r_a_q;
  assign alu_b       = r_b_q;
  assign alu_ctrl    = r_ctrl;
  assign done        = r_done;
  assign zero_flag   = r_zero_flag;

endmodule
